shift_pipe: RTL

//  Parametrised, pipelined barrel-shift execution unit for the MIPS core; successor to the single-cycle ALU shifter.

---
 rtl/shift_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel-shift execution unit (SLL/SRL/SRA/ROTR).
//
// The shift amount is consumed in STAGES register stages; stage i applies a
// contiguous slice of amount bits to the partial result it receives. Each
// stage carries valid, op, partial data, amount, SRA sign bit and tag.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   flush            squash every in-flight op; input is refused that cycle
//   in_valid/ready   operation handshake (in_op, in_data, in_amount, in_tag)
//   out_valid/ready  result handshake (out_data, out_tag)
module shift_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Amount bits handled per stage; trailing stages may get an empty slice.
  localparam int B = (int'(SHAMT_W) + int'(STAGES) - 1) / int'(STAGES);

  // Apply the amount bits belonging to one stage to a partial result.
  function automatic logic [WIDTH-1:0] shift_bits(input logic [1:0]         op,
                                                  input logic [WIDTH-1:0]   d,
                                                  input logic [SHAMT_W-1:0] amt,
                                                  input logic               sign,
                                                  input int                 stage);
    logic [WIDTH-1:0] r;
    int               lo;
    int               hi;
    lo = stage * B;
    hi = lo + B;
    if (hi > int'(SHAMT_W)) hi = int'(SHAMT_W);
    r = d;
    for (int b = 0; b < int'(SHAMT_W); b++) begin
      if (b >= lo && b < hi && amt[b]) begin
        case (op)
          2'b00:   r = r << (1 << b);
          2'b01:   r = r >> (1 << b);
          // Sign comes from the original operand, not the partial result.
          2'b10:   r = (r >> (1 << b)) | (sign ? ~({WIDTH{1'b1}} >> (1 << b)) : '0);
          default: r = (r >> (1 << b)) | (r << (WIDTH - (1 << b)));
        endcase
      end
    end
    return r;
  endfunction

  logic               vld_q  [STAGES];
  logic [1:0]         op_q   [STAGES];
  logic [WIDTH-1:0]   data_q [STAGES];
  logic [SHAMT_W-1:0] amt_q  [STAGES];
  logic               sign_q [STAGES];
  logic [TAG_W-1:0]   tag_q  [STAGES];

  // Inputs seen by each stage (from the ports for stage 0, else previous stage).
  logic               src_vld  [STAGES];
  logic [1:0]         src_op   [STAGES];
  logic [WIDTH-1:0]   src_data [STAGES];
  logic [SHAMT_W-1:0] src_amt  [STAGES];
  logic               src_sign [STAGES];
  logic [TAG_W-1:0]   src_tag  [STAGES];
  logic [WIDTH-1:0]   nxt_data [STAGES];

  logic en;
  logic accept;

  assign en        = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = en && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  always_comb begin
    src_vld[0]  = accept;
    src_op[0]   = in_op;
    src_data[0] = in_data;
    src_amt[0]  = in_amount;
    src_sign[0] = in_data[WIDTH-1];
    src_tag[0]  = in_tag;
    for (int i = 1; i < int'(STAGES); i++) begin
      src_vld[i]  = vld_q[i-1];
      src_op[i]   = op_q[i-1];
      src_data[i] = data_q[i-1];
      src_amt[i]  = amt_q[i-1];
      src_sign[i] = sign_q[i-1];
      src_tag[i]  = tag_q[i-1];
    end
    for (int i = 0; i < int'(STAGES); i++) begin
      nxt_data[i] = shift_bits(src_op[i], src_data[i], src_amt[i], src_sign[i], i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        vld_q[i]  <= 1'b0;
        op_q[i]   <= '0;
        data_q[i] <= '0;
        amt_q[i]  <= '0;
        sign_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        // Flush wins over both advance and handoff.
        if (flush) begin
          vld_q[i] <= 1'b0;
        end else if (en) begin
          vld_q[i] <= src_vld[i];
        end
        // Payload moves in lock-step with the pipe; bubbles are not compacted.
        if (en) begin
          op_q[i]   <= src_op[i];
          data_q[i] <= nxt_data[i];
          amt_q[i]  <= src_amt[i];
          sign_q[i] <= src_sign[i];
          tag_q[i]  <= src_tag[i];
        end
      end
    end
  end

endmodule
